// File: rtl/nv_nvdla_mcif_read_ig_pkg.sv
// Shared defaults for the MCIF read ingress arbiter slice.
// Also names the read client slots by their arbiter source index.
package nv_nvdla_mcif_read_ig_pkg;

    localparam int NUM_SRC_DEF = 10;
    localparam int PD_W_DEF    = 75;
    localparam int WT_W_DEF    = 8;
    localparam int ID_W_DEF    = 4;

    localparam int SRC_CDMA_DAT = 0;
    localparam int SRC_CDMA_WT  = 1;
    localparam int SRC_SDP      = 2;
    localparam int SRC_SDP_B    = 3;
    localparam int SRC_SDP_N    = 4;
    localparam int SRC_SDP_E    = 5;
    localparam int SRC_PDP      = 6;
    localparam int SRC_CDP      = 7;
    localparam int SRC_RBK      = 8;
    localparam int SRC_BDMA     = 9;

endpackage

// File: rtl/nv_nvdla_mcif_rr_pick.sv
// Rotating-priority find-first: the first set request strictly after ptr wins,
// wrapping at NUM_SRC. Purely combinational.
module nv_nvdla_mcif_rr_pick
    import nv_nvdla_mcif_read_ig_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_SRC-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_vld
);

    logic [2*NUM_SRC-1:0] req_rot;
    logic [ID_W:0]        off;
    logic [ID_W:0]        sum;
    logic                 found;

    always_comb begin
        // Rotating a doubled vector puts source ptr+1 at bit 0.
        req_rot = {req, req} >> ({1'b0, ptr} + 1'b1);
        off     = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && req_rot[k]) begin
                found = 1'b1;
                off   = (ID_W+1)'(k);
            end
        end
        sum = {1'b0, ptr} + 1'b1 + off;
        if (sum >= (ID_W+1)'(NUM_SRC)) begin
            sum = sum - (ID_W+1)'(NUM_SRC);
        end
        gnt_vld = |req;
        gnt_idx = sum[ID_W-1:0];
        gnt     = gnt_vld ? (NUM_SRC'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/nv_nvdla_mcif_read_ig_wrr_arb.sv
// Weighted round-robin arbiter for the MCIF read ingress path: one grant per
// cycle into a single registered output beat, per-source credits refilled from CSR weights.
module nv_nvdla_mcif_read_ig_wrr_arb
    import nv_nvdla_mcif_read_ig_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int PD_W    = PD_W_DEF,
    parameter int WT_W    = WT_W_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic [NUM_SRC-1:0]      src_vld,
    input  logic [NUM_SRC*PD_W-1:0] src_pd,
    output logic [NUM_SRC-1:0]      src_rdy,
    input  logic [NUM_SRC*WT_W-1:0] cfg_weight,
    output logic                    arb_out_vld,
    output logic [PD_W-1:0]         arb_out_pd,
    output logic [ID_W-1:0]         arb_out_id,
    input  logic                    arb_out_rdy
);

    logic [NUM_SRC-1:0][WT_W-1:0] weight;
    logic [NUM_SRC-1:0][WT_W-1:0] credit;
    logic [NUM_SRC-1:0][WT_W-1:0] credit_nxt;
    logic [NUM_SRC-1:0]           eligible;
    logic [NUM_SRC-1:0]           has_cred;
    logic [NUM_SRC-1:0]           cand;
    logic [NUM_SRC-1:0]           gnt_oh;
    logic [ID_W-1:0]              gnt_idx;
    logic [ID_W-1:0]              last_gnt;
    logic                         gnt_any;
    logic                         slot_free;
    logic                         refill;
    logic                         grant;
    logic [PD_W-1:0]              pd_sel;

    logic                         vld_p1;
    logic [PD_W-1:0]              pd_p1;
    logic [ID_W-1:0]              id_p1;

    assign weight = cfg_weight;

    // Stage p0: eligibility, credit-based candidate selection and pick
    always_comb begin
        eligible  = '0;
        has_cred  = '0;
        slot_free = !vld_p1 || arb_out_rdy;
        for (int i = 0; i < NUM_SRC; i++) begin
            eligible[i] = src_vld[i] && (weight[i] != '0);
            has_cred[i] = eligible[i] && (credit[i] != '0);
        end
        refill = slot_free && (|eligible) && !(|has_cred);
        cand   = (|has_cred) ? has_cred : eligible;
    end

    nv_nvdla_mcif_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_pick (
        .req     (cand),
        .ptr     (last_gnt),
        .gnt     (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_any)
    );

    always_comb begin
        grant      = slot_free && gnt_any && !nvdla_core_rst;
        src_rdy    = grant ? gnt_oh : '0;
        pd_sel     = '0;
        credit_nxt = credit;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_oh[i]) begin
                pd_sel = src_pd[i*PD_W +: PD_W];
            end
            // A refill round reloads every source, charging the winner its beat.
            if (refill) begin
                credit_nxt[i] = weight[i] - ((grant && gnt_oh[i]) ? WT_W'(1) : WT_W'(0));
            end else if (grant && gnt_oh[i]) begin
                credit_nxt[i] = credit[i] - WT_W'(1);
            end
        end
    end

    // Stage p1: registered output beat
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            vld_p1   <= 1'b0;
            pd_p1    <= '0;
            id_p1    <= '0;
            last_gnt <= ID_W'(NUM_SRC - 1);
            credit   <= '0;
        end else begin
            credit <= credit_nxt;
            if (slot_free) begin
                vld_p1 <= grant;
            end
            if (grant) begin
                pd_p1    <= pd_sel;
                id_p1    <= gnt_idx;
                last_gnt <= gnt_idx;
            end
        end
    end

    assign arb_out_vld = vld_p1;
    assign arb_out_pd  = pd_p1;
    assign arb_out_id  = id_p1;

endmodule

// File: tb/tb_nv_nvdla_mcif_read_ig_wrr_arb.sv
// Scoreboard bench for the WRR read ingress arbiter: directed streams push expected
// beats, a negedge monitor pops and compares every accepted output beat.
module tb_nv_nvdla_mcif_read_ig_wrr_arb;

    localparam int NUM_SRC = 10;
    localparam int PD_W    = 75;
    localparam int WT_W    = 8;
    localparam int ID_W    = 4;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [PD_W-1:0] pd;
    } beat_t;

    logic                    nvdla_core_clk;
    logic                    nvdla_core_rst;
    logic [NUM_SRC-1:0]      src_vld;
    logic [NUM_SRC*PD_W-1:0] src_pd;
    logic [NUM_SRC-1:0]      src_rdy;
    logic [NUM_SRC*WT_W-1:0] cfg_weight;
    logic                    arb_out_vld;
    logic [PD_W-1:0]         arb_out_pd;
    logic [ID_W-1:0]         arb_out_id;
    logic                    arb_out_rdy;

    beat_t exp_q[$];
    beat_t mon_b;
    int    chk_cnt  = 0;
    int    pass_cnt = 0;

    nv_nvdla_mcif_read_ig_wrr_arb #(
        .NUM_SRC (NUM_SRC),
        .PD_W    (PD_W),
        .WT_W    (WT_W),
        .ID_W    (ID_W)
    ) dut (
        .nvdla_core_clk (nvdla_core_clk),
        .nvdla_core_rst (nvdla_core_rst),
        .src_vld        (src_vld),
        .src_pd         (src_pd),
        .src_rdy        (src_rdy),
        .cfg_weight     (cfg_weight),
        .arb_out_vld    (arb_out_vld),
        .arb_out_pd     (arb_out_pd),
        .arb_out_id     (arb_out_id),
        .arb_out_rdy    (arb_out_rdy)
    );

    initial nvdla_core_clk = 1'b0;
    always #5 nvdla_core_clk = ~nvdla_core_clk;

    function automatic logic [PD_W-1:0] pd_of(input int s, input int tag);
        logic [10:0] t;
        logic [31:0] a;
        logic [31:0] b;
        t = tag[10:0];
        a = 32'hA5C3_0000 ^ (s * 32'h0101_0101);
        b = s + 1;
        return {t, a, b};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    task automatic step();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic set_pd(input int tag);
        for (int i = 0; i < NUM_SRC; i++) src_pd[i*PD_W +: PD_W] = pd_of(i, tag);
    endtask

    task automatic set_weights_all(input int w);
        for (int i = 0; i < NUM_SRC; i++) cfg_weight[i*WT_W +: WT_W] = w[WT_W-1:0];
    endtask

    task automatic set_weight(input int s, input int w);
        cfg_weight[s*WT_W +: WT_W] = w[WT_W-1:0];
    endtask

    task automatic push(input int id, input int tag);
        beat_t b;
        b.id = id[ID_W-1:0];
        b.pd = pd_of(id, tag);
        exp_q.push_back(b);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        nvdla_core_rst = 1'b1;
        src_vld        = '0;
        arb_out_rdy    = 1'b0;
        step();
        step();
        nvdla_core_rst = 1'b0;
    endtask

    always @(negedge nvdla_core_clk) begin
        if (!nvdla_core_rst && arb_out_vld && arb_out_rdy) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_beat: got id %0d, required no beat", arb_out_id);
            end else begin
                mon_b = exp_q.pop_front();
                check("out_id", arb_out_id, mon_b.id);
                check("out_pd", arb_out_pd, mon_b.pd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        nvdla_core_rst = 1'b1;
        src_vld        = '1;
        src_pd         = '0;
        cfg_weight     = '0;
        arb_out_rdy    = 1'b1;
        set_weights_all(1);
        set_pd(0);
        step();
        step();
        @(negedge nvdla_core_clk);
        check("rst_out_vld", arb_out_vld, 0);
        check("rst_out_pd", arb_out_pd, 0);
        check("rst_out_id", arb_out_id, 0);
        check("rst_src_rdy", src_rdy, 0);

        // Equal weights: plain round robin starting at src 0
        do_reset();
        set_weights_all(1);
        set_pd(1);
        arb_out_rdy = 1'b1;
        src_vld     = '1;
        for (int i = 0; i < 10; i++) push(i, 1);
        push(0, 1);
        repeat (11) step();
        src_vld = '0;
        drain();

        // src0 weight 3, src1 weight 1, others disabled
        do_reset();
        set_weights_all(0);
        set_weight(0, 3);
        set_weight(1, 1);
        set_pd(2);
        arb_out_rdy = 1'b1;
        src_vld     = '1;
        begin
            int seq2 [12] = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
            foreach (seq2[k]) push(seq2[k], 2);
        end
        repeat (12) step();
        src_vld = '0;
        drain();

        // Backpressure holds the beat even when the source payload changes
        do_reset();
        set_weights_all(1);
        set_pd(3);
        arb_out_rdy = 1'b0;
        src_vld     = 10'b00_0000_1000;
        push(3, 3);
        step();
        set_pd(33);
        for (int k = 0; k < 5; k++) begin
            @(negedge nvdla_core_clk);
            check("bp_out_vld", arb_out_vld, 1);
            check("bp_out_id", arb_out_id, 3);
            check("bp_out_pd", arb_out_pd, pd_of(3, 3));
            check("bp_src_rdy", src_rdy, 0);
            step();
        end
        arb_out_rdy = 1'b1;
        src_vld     = '0;
        drain();
        @(negedge nvdla_core_clk);
        check("bp_after_accept_vld", arb_out_vld, 0);

        // Weight-0 source is never granted
        do_reset();
        set_weights_all(1);
        set_weight(2, 0);
        set_pd(4);
        arb_out_rdy = 1'b1;
        src_vld     = 10'b00_0000_0100;
        for (int k = 0; k < 4; k++) begin
            @(negedge nvdla_core_clk);
            check("w0_out_vld", arb_out_vld, 0);
            check("w0_src_rdy", src_rdy, 0);
            step();
        end
        src_vld = '0;

        // Weight change mid-round applies from the next refill
        do_reset();
        set_weights_all(0);
        set_weight(0, 3);
        set_weight(1, 1);
        set_pd(5);
        arb_out_rdy = 1'b1;
        src_vld     = 10'b00_0000_0011;
        begin
            int seq5 [8] = '{0, 1, 0, 0, 1, 0, 1, 0};
            foreach (seq5[k]) push(seq5[k], 5);
        end
        repeat (3) step();
        set_weight(0, 1);
        repeat (5) step();
        src_vld = '0;
        drain();

        // Reset with a beat in flight drops it and restarts at src 0
        do_reset();
        set_weights_all(1);
        set_pd(6);
        arb_out_rdy = 1'b1;
        src_vld     = '1;
        push(0, 6);
        push(1, 6);
        repeat (3) step();
        nvdla_core_rst = 1'b1;
        arb_out_rdy    = 1'b0;
        step();
        @(negedge nvdla_core_clk);
        check("midrst_out_vld", arb_out_vld, 0);
        check("midrst_out_id", arb_out_id, 0);
        check("midrst_out_pd", arb_out_pd, 0);
        check("midrst_src_rdy", src_rdy, 0);
        step();
        nvdla_core_rst = 1'b0;
        arb_out_rdy    = 1'b1;
        push(0, 6);
        push(1, 6);
        repeat (2) step();
        src_vld = '0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
